// File: rtl/issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : issue_ctrl_if
// Description : ID-stage fields, pipeline events and issue-control outputs
//               exchanged between the core pipeline and issue_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface issue_ctrl_if #(
  parameter int CNT_W = 32
) ();
  logic             id_valid;
  logic [6:0]       id_opcode;
  logic [4:0]       id_rd;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             ex_redirect;
  logic             dmem_busy;
  logic             if_stall;
  logic             id_stall;
  logic             id_flush;
  logic             ex_bubble;
  logic             mem_wb_hold;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;

  // Pipeline side: supplies decoder fields and events, consumes controls
  modport master (
    output id_valid, id_opcode, id_rd, id_rs1, id_rs2, ex_redirect, dmem_busy,
    input  if_stall, id_stall, id_flush, ex_bubble, mem_wb_hold,
           fwd_a, fwd_b, stall_cnt
  );

  // Controller side
  modport slave (
    input  id_valid, id_opcode, id_rd, id_rs1, id_rs2, ex_redirect, dmem_busy,
    output if_stall, id_stall, id_flush, ex_bubble, mem_wb_hold,
           fwd_a, fwd_b, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : issue_ctrl
// Description : Issue controller for a 5-stage RV32I pipeline. Tracks the
//               destination registers in flight, detects load-use hazards,
//               produces stall/flush/bubble controls, registered EX forward
//               selects and a stall-cycle counter. Freezes on dmem_busy.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  wire logic   clk,
  input  wire logic   reset,
  issue_ctrl_if.slave bus
);

  localparam logic [6:0]       c_OP_LOAD    = 7'b0000011;
  localparam logic [1:0]       c_FCNT_INIT  = 2'(FLUSH_CYCLES - 1);
  localparam logic [1:0]       c_FWD_RF     = 2'b00;
  localparam logic [1:0]       c_FWD_EXMEM  = 2'b01;
  localparam logic [1:0]       c_FWD_MEMWB  = 2'b10;
  localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_FREEZE = 2'd2
  } state_t;

  // In-flight destination tag for the instruction in EX
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       ld;
  } tag_t;

  state_t           r_state;
  logic [1:0]       r_fcnt;
  tag_t             r_ex_tag;
  // MEM only needs valid/rd: a load there is forwarded from MEM/WB like any
  // other result. WB-stage results reach ID through the write-through
  // regfile, so no WB tag has to be kept.
  logic             r_mem_v;
  logic [4:0]       r_mem_rd;
  logic [1:0]       r_fwd_a;
  logic [1:0]       r_fwd_b;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_lu;
  logic w_issue;
  logic w_if_stall;
  logic w_id_stall;
  logic w_id_flush;
  logic w_ex_bubble;
  logic w_mem_wb_hold;

  // Forward select for one source operand; EX match wins over MEM match
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input tag_t ex,
                                         input logic mem_v, input logic [4:0] mem_rd);
    logic [1:0] sel;
    sel = c_FWD_RF;
    if (rs != 5'd0 && ex.v && !ex.ld && ex.rd == rs) begin
      sel = c_FWD_EXMEM;
    end else if (rs != 5'd0 && mem_v && mem_rd == rs) begin
      sel = c_FWD_MEMWB;
    end
    return sel;
  endfunction

  // Load in EX whose result is needed by the instruction in ID
  always_comb begin
    w_lu = bus.id_valid && r_ex_tag.v && r_ex_tag.ld &&
           ((bus.id_rs1 != 5'd0 && bus.id_rs1 == r_ex_tag.rd) ||
            (bus.id_rs2 != 5'd0 && bus.id_rs2 == r_ex_tag.rd));
  end

  // Control outputs by priority: reset > dmem_busy > redirect/FLUSH > load-use
  always_comb begin
    w_if_stall    = 1'b0;
    w_id_stall    = 1'b0;
    w_id_flush    = 1'b0;
    w_ex_bubble   = 1'b0;
    w_mem_wb_hold = 1'b0;
    if (reset) begin
      w_if_stall = 1'b0;
    end else if (bus.dmem_busy) begin
      w_if_stall    = 1'b1;
      w_id_stall    = 1'b1;
      w_mem_wb_hold = 1'b1;
    end else if (bus.ex_redirect || r_state == ST_FLUSH) begin
      w_id_flush  = 1'b1;
      w_ex_bubble = 1'b1;
    end else if (w_lu) begin
      w_if_stall  = 1'b1;
      w_id_stall  = 1'b1;
      w_ex_bubble = 1'b1;
    end
  end

  // The ID instruction moves into EX this cycle
  always_comb begin
    w_issue = bus.id_valid && !w_id_stall && !w_id_flush &&
              !bus.dmem_busy && !bus.ex_redirect;
  end

  // Redirect/freeze sequencing; the flush counter is kept untouched while
  // memory is busy so the remaining flush cycles resume afterwards
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_fcnt  <= 2'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.dmem_busy) begin
            r_state <= ST_FREEZE;
          end else if (bus.ex_redirect) begin
            r_state <= ST_FLUSH;
            r_fcnt  <= c_FCNT_INIT;
          end
        end
        ST_FLUSH: begin
          if (!bus.dmem_busy) begin
            if (bus.ex_redirect) begin
              r_fcnt <= c_FCNT_INIT;
            end else if (r_fcnt == 2'd0) begin
              r_state <= ST_RUN;
            end else begin
              r_fcnt <= r_fcnt - 2'd1;
            end
          end
        end
        ST_FREEZE: begin
          if (!bus.dmem_busy) begin
            if (bus.ex_redirect) begin
              r_state <= ST_FLUSH;
              r_fcnt  <= c_FCNT_INIT;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_fcnt  <= 2'd0;
        end
      endcase
    end
  end

  // Tag pipeline and forward selects advance together, frozen on dmem_busy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_tag <= '0;
      r_mem_v  <= 1'b0;
      r_mem_rd <= 5'd0;
      r_fwd_a  <= c_FWD_RF;
      r_fwd_b  <= c_FWD_RF;
    end else if (!bus.dmem_busy) begin
      r_mem_v  <= r_ex_tag.v;
      r_mem_rd <= r_ex_tag.rd;
      if (w_issue) begin
        r_ex_tag.v  <= (bus.id_rd != 5'd0);
        r_ex_tag.rd <= bus.id_rd;
        r_ex_tag.ld <= (bus.id_opcode == c_OP_LOAD);
        r_fwd_a     <= fwd_sel(bus.id_rs1, r_ex_tag, r_mem_v, r_mem_rd);
        r_fwd_b     <= fwd_sel(bus.id_rs2, r_ex_tag, r_mem_v, r_mem_rd);
      end else begin
        r_ex_tag <= '0;
        r_fwd_a  <= c_FWD_RF;
        r_fwd_b  <= c_FWD_RF;
      end
    end
  end

  // Count cycles in which the front end is held
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_if_stall) begin
      r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
    end
  end

  assign bus.if_stall    = w_if_stall;
  assign bus.id_stall    = w_id_stall;
  assign bus.id_flush    = w_id_flush;
  assign bus.ex_bubble   = w_ex_bubble;
  assign bus.mem_wb_hold = w_mem_wb_hold;
  assign bus.fwd_a       = r_fwd_a;
  assign bus.fwd_b       = r_fwd_b;
  assign bus.stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_ctrl
// Description : Directed self-checking bench for issue_ctrl, instantiated
//               with FLUSH_CYCLES=2 and CNT_W=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_ctrl;

  localparam logic [6:0] c_LD = 7'b0000011;
  localparam logic [6:0] c_OP = 7'b0110011;
  // {if_stall, id_stall, id_flush, ex_bubble, mem_wb_hold}
  localparam logic [4:0] c_IDLE = 5'b00000;
  localparam logic [4:0] c_LU   = 5'b11010;
  localparam logic [4:0] c_FL   = 5'b00110;
  localparam logic [4:0] c_BUSY = 5'b11001;

  typedef struct {
    string      tag;
    logic [4:0] ctrl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [3:0] cnt;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  exp_t sb[$];

  issue_ctrl_if #(.CNT_W(4)) bus ();

  issue_ctrl #(
    .FLUSH_CYCLES(2),
    .CNT_W(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: drive after the edge, record expectations, check mid-cycle
  task automatic step(input string tag, input logic rst, input logic v,
                      input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic redir, input logic busy,
                      input logic [4:0] ectrl, input logic [1:0] efa,
                      input logic [1:0] efb, input logic [3:0] ecnt);
    exp_t e;
    exp_t g;
    logic [4:0] octrl;
    @(posedge clk);
    #1;
    reset           = rst;
    bus.id_valid    = v;
    bus.id_opcode   = op;
    bus.id_rd       = rd;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.ex_redirect = redir;
    bus.dmem_busy   = busy;
    e.tag  = tag;
    e.ctrl = ectrl;
    e.fa   = efa;
    e.fb   = efb;
    e.cnt  = ecnt;
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    octrl = {bus.if_stall, bus.id_stall, bus.id_flush, bus.ex_bubble, bus.mem_wb_hold};
    total++;
    assert (octrl === g.ctrl) else begin
      bad++;
      $error("FAIL %s ctrl observed=%b expected=%b", g.tag, octrl, g.ctrl);
    end
    total++;
    assert (bus.fwd_a === g.fa) else begin
      bad++;
      $error("FAIL %s fwd_a observed=%b expected=%b", g.tag, bus.fwd_a, g.fa);
    end
    total++;
    assert (bus.fwd_b === g.fb) else begin
      bad++;
      $error("FAIL %s fwd_b observed=%b expected=%b", g.tag, bus.fwd_b, g.fb);
    end
    total++;
    assert (bus.stall_cnt === g.cnt) else begin
      bad++;
      $error("FAIL %s stall_cnt observed=%0d expected=%0d", g.tag, bus.stall_cnt, g.cnt);
    end
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    reset           = 1'b1;
    bus.id_valid    = 1'b0;
    bus.id_opcode   = 7'd0;
    bus.id_rd       = 5'd0;
    bus.id_rs1      = 5'd0;
    bus.id_rs2      = 5'd0;
    bus.ex_redirect = 1'b0;
    bus.dmem_busy   = 1'b0;

    //    tag          rst v  op    rd  rs1 rs2 rdr bsy ctrl    fa     fb     cnt
    step("reset",      1, 1, c_LD, 5,  2,  0,  0,  0, c_IDLE, 2'b00, 2'b00, 4'd0);
    // load-use: lw x5 ; add x6,x5,x1
    step("lw_x5",      0, 1, c_LD, 5,  2,  0,  0,  0, c_IDLE, 2'b00, 2'b00, 4'd0);
    step("lu_stall",   0, 1, c_OP, 6,  5,  1,  0,  0, c_LU,   2'b00, 2'b00, 4'd0);
    step("lu_issue",   0, 1, c_OP, 6,  5,  1,  0,  0, c_IDLE, 2'b00, 2'b00, 4'd1);
    // EX forwarding: add x3,x1,x2 ; sub x4,x3,x3 ; then x0 cases
    step("add_x3",     0, 1, c_OP, 3,  1,  2,  0,  0, c_IDLE, 2'b10, 2'b00, 4'd1);
    step("sub_x4",     0, 1, c_OP, 4,  3,  3,  0,  0, c_IDLE, 2'b00, 2'b00, 4'd1);
    step("add_x0",     0, 1, c_OP, 0,  4,  1,  0,  0, c_IDLE, 2'b01, 2'b01, 4'd1);
    step("use_x0",     0, 1, c_OP, 7,  0,  0,  0,  0, c_IDLE, 2'b01, 2'b00, 4'd1);
    // redirect: pulse cycle plus two FLUSH cycles
    step("redir",      0, 1, c_OP, 8,  7,  1,  1,  0, c_FL,   2'b00, 2'b00, 4'd1);
    step("flush1",     0, 1, c_OP, 9,  7,  7,  0,  0, c_FL,   2'b00, 2'b00, 4'd1);
    step("flush2",     0, 1, c_OP, 9,  7,  7,  0,  0, c_FL,   2'b00, 2'b00, 4'd1);
    step("post_fl",    0, 1, c_OP, 10, 8,  9,  0,  0, c_IDLE, 2'b00, 2'b00, 4'd1);
    step("lw_x11",     0, 1, c_LD, 11, 10, 0,  0,  0, c_IDLE, 2'b00, 2'b00, 4'd1);
    // load-use and redirect together: flush wins, no stall counted
    step("lu_redir",   0, 1, c_OP, 12, 11, 0,  1,  0, c_FL,   2'b01, 2'b00, 4'd1);
    // dmem_busy for 3 cycles inside FLUSH, then the remaining flush cycles
    step("fl_busy1",   0, 1, c_OP, 12, 11, 0,  0,  1, c_BUSY, 2'b00, 2'b00, 4'd1);
    step("fl_busy2",   0, 1, c_OP, 12, 11, 0,  0,  1, c_BUSY, 2'b00, 2'b00, 4'd2);
    step("fl_busy3",   0, 1, c_OP, 12, 11, 0,  0,  1, c_BUSY, 2'b00, 2'b00, 4'd3);
    step("fl_rest1",   0, 1, c_OP, 12, 11, 0,  0,  0, c_FL,   2'b00, 2'b00, 4'd4);
    step("fl_rest2",   0, 1, c_OP, 12, 11, 0,  0,  0, c_FL,   2'b00, 2'b00, 4'd4);
    // freeze with a load in MEM
    step("add_x20",    0, 1, c_OP, 20, 1,  2,  0,  0, c_IDLE, 2'b00, 2'b00, 4'd4);
    step("lw_x13",     0, 1, c_LD, 13, 20, 0,  0,  0, c_IDLE, 2'b00, 2'b00, 4'd4);
    step("add_x14",    0, 1, c_OP, 14, 20, 1,  0,  0, c_IDLE, 2'b01, 2'b00, 4'd4);
    step("frz1",       0, 1, c_OP, 15, 13, 14, 0,  1, c_BUSY, 2'b10, 2'b00, 4'd4);
    step("frz2",       0, 1, c_OP, 15, 13, 14, 0,  1, c_BUSY, 2'b10, 2'b00, 4'd5);
    step("frz3",       0, 1, c_OP, 15, 13, 14, 0,  1, c_BUSY, 2'b10, 2'b00, 4'd6);
    step("frz4",       0, 1, c_OP, 15, 13, 14, 0,  1, c_BUSY, 2'b10, 2'b00, 4'd7);
    step("frz_exit",   0, 1, c_OP, 15, 13, 14, 0,  0, c_IDLE, 2'b10, 2'b00, 4'd8);
    step("frz_fwd",    0, 0, c_OP, 0,  0,  0,  0,  0, c_IDLE, 2'b10, 2'b01, 4'd8);
    // reset while in FLUSH
    step("redir2",     0, 0, c_OP, 0,  0,  0,  1,  0, c_FL,   2'b00, 2'b00, 4'd8);
    step("rst_flush",  1, 1, c_OP, 1,  2,  3,  0,  0, c_IDLE, 2'b00, 2'b00, 4'd8);
    step("post_rst",   0, 1, c_OP, 1,  2,  3,  0,  0, c_IDLE, 2'b00, 2'b00, 4'd0);
    // 17 busy cycles wrap the 4-bit counter to 1
    for (int k = 0; k < 17; k++) begin
      step("wrap", 0, 0, c_OP, 0, 0, 0, 0, 1, c_BUSY, 2'b00, 2'b00, 4'(k % 16));
    end
    step("wrap_end",   0, 0, c_OP, 0,  0,  0,  0,  0, c_IDLE, 2'b00, 2'b00, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
